// File: rtl/plic_if.sv
// Bus-side port bundle of the PLIC: a single-outstanding D-bus slave window.
// Handshake: the slave samples a request on a rising edge where bus_req=1 and
// bus_ack=0, then raises bus_ack for exactly one cycle with bus_rdata valid;
// bus_req seen while bus_ack=1 is ignored, so a held request costs two cycles.
interface plic_if;
   logic        bus_req;
   logic        bus_we;
   logic [9:0]  bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ack;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata,
      input  bus_rdata, bus_ack
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata,
      output bus_rdata, bus_ack
   );
endinterface

// File: rtl/plic.sv
// Platform-level interrupt controller: level gateways, per-source priority and
// enable, one threshold, claim/complete register pair and a registered irq_ext.
module plic #(
   parameter int NSRC   = 8,
   parameter int PRIO_W = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NSRC-1:0] src,
   plic_if.slave           bus,
   output logic            irq_ext
);

   localparam logic [7:0] W_PEND  = 8'h20;
   localparam logic [7:0] W_EN    = 8'h40;
   localparam logic [7:0] W_THR   = 8'h80;
   localparam logic [7:0] W_CLAIM = 8'h81;

   logic [PRIO_W-1:0] prio [1:NSRC];
   logic [NSRC:1]     enable;
   logic [NSRC:1]     pending;
   logic [NSRC:1]     inflight;
   logic [PRIO_W-1:0] threshold;

   logic [7:0]        word;
   logic              take;
   logic [31:0]       claim_id;
   logic [PRIO_W-1:0] best_prio;
   logic [31:0]       rdata_next;
   logic              irq_next;
   logic [NSRC:1]     claim_hit;
   logic [NSRC:1]     comp_hit;
   logic              unused_addr;

   assign word        = bus.bus_addr[9:2];
   assign take        = bus.bus_req && !bus.bus_ack;
   assign unused_addr = &{1'b0, bus.bus_addr[1:0]};

   // Strictly-greater scan from ID 1 upward keeps the lowest ID on ties and
   // never selects a priority-0 source.
   always_comb begin
      claim_id  = '0;
      best_prio = '0;
      for (int i = 1; i <= NSRC; i++) begin
         if (pending[i] && enable[i] && (prio[i] > best_prio)) begin
            best_prio = prio[i];
            claim_id  = 32'(i);
         end
      end
   end

   always_comb begin
      irq_next = 1'b0;
      for (int i = 1; i <= NSRC; i++) begin
         if (pending[i] && enable[i] && (prio[i] > threshold)) irq_next = 1'b1;
      end
   end

   always_comb begin
      rdata_next = '0;
      for (int i = 1; i <= NSRC; i++) begin
         if (word == 8'(i)) rdata_next = 32'(prio[i]);
      end
      case (word)
         W_PEND:  rdata_next[NSRC:0] = {pending, 1'b0};
         W_EN:    rdata_next[NSRC:0] = {enable, 1'b0};
         W_THR:   rdata_next         = 32'(threshold);
         W_CLAIM: rdata_next         = claim_id;
         default: ;
      endcase
   end

   always_comb begin
      claim_hit = '0;
      comp_hit  = '0;
      for (int i = 1; i <= NSRC; i++) begin
         claim_hit[i] = take && !bus.bus_we && (word == W_CLAIM) && (claim_id == 32'(i));
         comp_hit[i]  = take && bus.bus_we && (word == W_CLAIM) &&
                        (bus.bus_wdata == 32'(i)) && inflight[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 1; i <= NSRC; i++) prio[i] <= '0;
         enable        <= '0;
         pending       <= '0;
         inflight      <= '0;
         threshold     <= '0;
         bus.bus_ack   <= 1'b0;
         bus.bus_rdata <= '0;
         irq_ext       <= 1'b0;
      end else begin
         bus.bus_ack   <= take;
         bus.bus_rdata <= take ? rdata_next : '0;
         irq_ext       <= irq_next;

         // A claim beats a same-cycle gateway hit; a completion only frees the
         // gateway, so re-pending waits for the next edge.
         for (int i = 1; i <= NSRC; i++) begin
            if (claim_hit[i]) begin
               pending[i]  <= 1'b0;
               inflight[i] <= 1'b1;
            end else if (src[i-1] && !pending[i] && !inflight[i]) begin
               pending[i] <= 1'b1;
            end
            if (comp_hit[i]) inflight[i] <= 1'b0;
         end

         if (take && bus.bus_we) begin
            for (int i = 1; i <= NSRC; i++) begin
               if (word == 8'(i)) prio[i] <= bus.bus_wdata[PRIO_W-1:0];
            end
            if (word == W_EN)  enable    <= bus.bus_wdata[NSRC:1];
            if (word == W_THR) threshold <= bus.bus_wdata[PRIO_W-1:0];
         end
      end
   end

endmodule

// File: doc/plic.md
PLIC -- requirements
Module: plic

Interface
REQ-001 SHALL have parameter NSRC, default 8, meaning number of interrupt sources, IDs 1..NSRC, ID 0 reserved for "none".
REQ-002 SHALL have parameter PRIO_W, default 3, meaning priority and threshold width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port src, input, NSRC, level interrupt sources; bit i-1 is ID i; synchronous to clk.
REQ-006 SHALL have port bus_req, input, 1, D-bus slave access request.
REQ-007 SHALL have port bus_we, input, 1, 1 = write, 0 = read.
REQ-008 SHALL have port bus_addr, input, 10, byte offset inside the PLIC window; bits [1:0] ignored.
REQ-009 SHALL have port bus_wdata, input, 32, write data.
REQ-010 SHALL have port bus_rdata, output, 32, read data, valid while bus_ack=1.
REQ-011 SHALL have port bus_ack, output, 1, one-cycle access completion.
REQ-012 SHALL have port irq_ext, output, 1, registered external interrupt request to rv_core.

Function
REQ-013 SHALL use this register map: 0x004*i = priority[i] (i=1..NSRC, RW, low PRIO_W bits); 0x000 = 0 (RO); 0x080 = pending bits [NSRC:1] (RO); 0x100 = enable bits [NSRC:1] (RW); 0x200 = threshold (RW, low PRIO_W bits); 0x204 = claim (read) / complete (write).
REQ-014 SHALL read unmapped offsets as 0, ignore writes to them, and read unused upper bits of every register as 0.
REQ-015 SHALL sample a request on a cycle where bus_req=1 and bus_ack=0, then assert bus_ack for exactly one cycle on the next cycle with bus_rdata valid.
REQ-016 SHALL ignore bus_req on the cycle bus_ack=1, so a held bus_req gives one access every 2 cycles.
REQ-017 SHALL apply the register write on the sampling edge, so bus_ack marks the first cycle the new value is visible.
REQ-018 SHALL set pending[i] when src[i]=1, pending[i]=0 and inflight[i]=0 (gateway); pending is never cleared by src deasserting.
REQ-019 SHALL, on a claim read, return the ID with pending=1, enable=1 and priority>0 that has the highest priority, ties to lowest ID, else 0.
REQ-020 SHALL, on a nonzero claim, clear pending[ID] and set inflight[ID] on the sampling edge.
REQ-021 SHALL NOT apply threshold to the claim result.
REQ-022 SHALL, on a complete write of ID in 1..NSRC with inflight[ID]=1, clear inflight[ID]; all other complete writes SHALL be ignored, regardless of enable.
REQ-023 SHALL register irq_ext = 1 iff some i has pending=1, enable=1 and priority[i]>threshold.
REQ-024 SHALL meet this latency: src rising in cycle N -> pending set at end of N -> irq_ext=1 in cycle N+2.
REQ-025 SHALL resolve simultaneous claim of ID i and src[i]=1 as claim wins, with no re-pend that cycle.
REQ-026 SHALL resolve simultaneous complete of ID i and src[i]=1 by clearing inflight first, with pending re-set no earlier than the following cycle.
REQ-027 SHALL never interrupt or claim a priority-0 source; it may still pend.
REQ-028 SHALL never let irq_ext interrupt when threshold=max (2^PRIO_W-1).

Reset
REQ-029 SHALL, while rst=1, clear priority, enable, threshold, pending and inflight, and drive bus_ack=0, bus_rdata=0, irq_ext=0.
REQ-030 SHALL drop an access in flight when rst asserts, with no ack after reset.
REQ-031 SHALL have src levels during reset leave no pending after reset; gateways sample from the first cycle with rst=0.

Verification
REQ-032 SHALL cover basic: prio[3]=2, enable=0x08, threshold=0, pulse src[2] -> irq_ext=1 two cycles later; claim reads 3; irq_ext=0 next cycle; pending=0.
REQ-033 SHALL cover arbitration: prio[1]=1, prio[5]=4, prio[6]=4, all enabled and pending -> claims return 5, then 6, then 1, then 0.
REQ-034 SHALL cover threshold: prio[2]=3, threshold=3 -> irq_ext stays 0 while claim still returns 2; threshold=2 -> irq_ext=1.
REQ-035 SHALL cover gateway: src[0] held high, claim 1, no complete -> pending[1] stays 0; complete 1 -> pending[1]=1 the cycle after next; complete 4 while not inflight -> no state change.
REQ-036 SHALL cover collisions: claim of 2 with src[1] high in the same cycle -> pending stays 0; complete with src high -> re-pend one cycle later.
REQ-037 SHALL cover reset mid-operation: rst asserted during the ack cycle and with pending/inflight set -> all registers read 0 and irq_ext=0 after release.
